// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle RV32I control sequencer (fetch/decode/exec/mem/wb)
module riscv_mc_ctrl #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  input  logic [BUS_WIDTH-1:0] i_INSTR,
  input  logic                 i_MEM_READY,
  input  logic                 i_BR_TAKEN,
  output logic                 o_MEM_REQ,
  output logic                 o_MEM_WE,
  output logic                 o_ADDR_SRC,
  output logic                 o_IR_WE,
  output logic                 o_PC_WE,
  output logic [1:0]           o_PC_SRC,
  output logic                 o_ALU_SRCA,
  output logic                 o_ALU_SRCB,
  output logic [3:0]           o_ALU_OP,
  output logic                 o_REG_WE,
  output logic [1:0]           o_WB_SRC,
  output logic [2:0]           o_STATE,
  output logic                 o_ILLEGAL
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;
  state_t state, state_nxt;
  logic illegal;
  logic [6:0] opc;
  logic [2:0] f3;
  logic alt, alu_act, legal;
  logic is_r, is_opi, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic unused_instr;
  assign opc = i_INSTR[6:0];
  assign f3 = i_INSTR[14:12];
  assign alt = i_INSTR[30];
  assign unused_instr = ^{i_INSTR[BUS_WIDTH-1:31], i_INSTR[29:15], i_INSTR[11:7]};
  assign is_r = opc == 7'b0110011;
  assign is_opi = opc == 7'b0010011;
  assign is_load = opc == 7'b0000011;
  assign is_store = opc == 7'b0100011;
  assign is_branch = opc == 7'b1100011;
  assign is_jal = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111;
  assign is_lui = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  // every listed opcode ends in 2'b11, so the low-bit rule is implied by this match
  assign legal = is_r | is_opi | is_load | is_store | is_branch | is_jal | is_jalr | is_lui | is_auipc;
  // ALU controls are decoded from the opcode and held through EXEC, MEM and WB
  assign alu_act = state == EXEC || state == MEM || state == WB;
  assign o_ALU_OP = !alu_act ? 4'd0 :
                    is_branch ? 4'b1000 :
                    (is_r || (is_opi && f3 == 3'b101)) ? {alt, f3} :
                    is_opi ? {1'b0, f3} : 4'd0;
  assign o_ALU_SRCA = alu_act && is_auipc;
  assign o_ALU_SRCB = alu_act && (is_opi || is_load || is_store || is_auipc || is_jalr);
  assign o_STATE = state;
  assign o_ILLEGAL = illegal;
  // state register and sticky illegal flag
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state <= FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == DECODE && !legal) illegal <= 1'b1;
    end
  end
  // next-state and datapath enables
  always_comb begin
    state_nxt = state;
    o_MEM_REQ = 1'b0;
    o_MEM_WE = 1'b0;
    o_ADDR_SRC = 1'b0;
    o_IR_WE = 1'b0;
    o_PC_WE = 1'b0;
    o_PC_SRC = 2'd0;
    o_REG_WE = 1'b0;
    o_WB_SRC = 2'd0;
    case (state)
      FETCH: begin
        o_MEM_REQ = 1'b1;
        o_IR_WE = i_MEM_READY;
        o_PC_WE = i_MEM_READY;
        if (i_MEM_READY) state_nxt = DECODE;
      end
      DECODE: state_nxt = legal ? EXEC : HALT;
      EXEC: begin
        o_PC_WE = is_jal || is_jalr || (is_branch && i_BR_TAKEN);
        o_PC_SRC = is_jalr ? 2'd2 : (is_jal || is_branch) ? 2'd1 : 2'd0;
        o_REG_WE = is_jal || is_jalr;
        o_WB_SRC = (is_jal || is_jalr) ? 2'd2 : 2'd0;
        state_nxt = (is_load || is_store) ? MEM : (is_branch || is_jal || is_jalr) ? FETCH : WB;
      end
      MEM: begin
        o_MEM_REQ = 1'b1;
        o_ADDR_SRC = 1'b1;
        o_MEM_WE = is_store;
        if (i_MEM_READY) state_nxt = is_load ? WB : FETCH;
      end
      WB: begin
        o_REG_WE = 1'b1;
        o_WB_SRC = is_load ? 2'd1 : is_lui ? 2'd3 : 2'd0;
        state_nxt = FETCH;
      end
      default: state_nxt = HALT;
    endcase
  end
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: randomized self-checking bench for the multi-cycle control unit
module tb_riscv_mc_ctrl;
  localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_H = 5;
  localparam int C_R = 0, C_OPI = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8;
  logic i_CLK = 0, i_RST_N = 0, i_MEM_READY = 0, i_BR_TAKEN = 0;
  logic [31:0] i_INSTR = '0;
  logic o_MEM_REQ, o_MEM_WE, o_ADDR_SRC, o_IR_WE, o_PC_WE, o_ALU_SRCA, o_ALU_SRCB, o_REG_WE, o_ILLEGAL;
  logic [1:0] o_PC_SRC, o_WB_SRC;
  logic [3:0] o_ALU_OP;
  logic [2:0] o_STATE;
  logic exp_ill = 0;
  int errors = 0, checks = 0;

  riscv_mc_ctrl #(.BUS_WIDTH(32)) dut (
    .i_CLK(i_CLK), .i_RST_N(i_RST_N), .i_INSTR(i_INSTR), .i_MEM_READY(i_MEM_READY),
    .i_BR_TAKEN(i_BR_TAKEN), .o_MEM_REQ(o_MEM_REQ), .o_MEM_WE(o_MEM_WE), .o_ADDR_SRC(o_ADDR_SRC),
    .o_IR_WE(o_IR_WE), .o_PC_WE(o_PC_WE), .o_PC_SRC(o_PC_SRC), .o_ALU_SRCA(o_ALU_SRCA),
    .o_ALU_SRCB(o_ALU_SRCB), .o_ALU_OP(o_ALU_OP), .o_REG_WE(o_REG_WE), .o_WB_SRC(o_WB_SRC),
    .o_STATE(o_STATE), .o_ILLEGAL(o_ILLEGAL)
  );

  always #5 i_CLK = ~i_CLK;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int cls_of(input logic [31:0] ins);
    if (ins[1:0] != 2'b11) return -1;
    case (ins[6:0])
      7'b0110011: return C_R;
      7'b0010011: return C_OPI;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default: return -1;
    endcase
  endfunction

  function automatic logic [6:0] opc_of(input int c);
    case (c)
      C_R: return 7'b0110011;
      C_OPI: return 7'b0010011;
      C_LD: return 7'b0000011;
      C_ST: return 7'b0100011;
      C_BR: return 7'b1100011;
      C_JAL: return 7'b1101111;
      C_JALR: return 7'b1100111;
      C_LUI: return 7'b0110111;
      default: return 7'b0010111;
    endcase
  endfunction

  // expected control word {req,we,asrc,irwe,pcwe,pcsrc[2],sa,sb,aop[4],rwe,wbs[2]}
  function automatic logic [15:0] model(input int st, input logic [31:0] ins, input logic rdy, input logic br);
    int c;
    logic [15:0] v;
    logic [2:0] f3;
    c = cls_of(ins);
    f3 = ins[14:12];
    v = '0;
    if (st == S_E || st == S_M || st == S_W) begin
      v[8] = c == C_AUIPC;
      v[7] = c inside {C_OPI, C_LD, C_ST, C_AUIPC, C_JALR};
      if (c == C_R || (c == C_OPI && f3 == 3'd5)) v[6:3] = {ins[30], f3};
      else if (c == C_OPI) v[6:3] = {1'b0, f3};
      else if (c == C_BR) v[6:3] = 4'b1000;
    end
    case (st)
      S_F: begin v[15] = 1; v[12] = rdy; v[11] = rdy; end
      S_E: begin
        if (c == C_BR) begin v[11] = br; v[10:9] = 2'd1; end
        if (c == C_JAL || c == C_JALR) begin
          v[11] = 1; v[10:9] = (c == C_JAL) ? 2'd1 : 2'd2; v[2] = 1; v[1:0] = 2'd2;
        end
      end
      S_M: begin v[15] = 1; v[13] = 1; v[14] = c == C_ST; end
      S_W: begin v[2] = 1; v[1:0] = (c == C_LD) ? 2'd1 : (c == C_LUI) ? 2'd3 : 2'd0; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic now(input int st);
    logic [15:0] e, o;
    e = model(st, i_INSTR, i_MEM_READY, i_BR_TAKEN);
    o = {o_MEM_REQ, o_MEM_WE, o_ADDR_SRC, o_IR_WE, o_PC_WE, o_PC_SRC, o_ALU_SRCA, o_ALU_SRCB,
         o_ALU_OP, o_REG_WE, o_WB_SRC};
    if (!e[11]) begin e[10:9] = 2'd0; o[10:9] = 2'd0; end
    chk("state", {29'd0, o_STATE}, st);
    chk("ctrl", {16'd0, o}, {16'd0, e});
    chk("illegal", {31'd0, o_ILLEGAL}, {31'd0, exp_ill});
  endtask

  task automatic look(input int st);
    @(negedge i_CLK);
    now(st);
    @(posedge i_CLK);
    #1;
  endtask

  task automatic do_reset();
    i_RST_N = 0;
    i_MEM_READY = 0;
    exp_ill = 0;
    repeat (3) look(S_F);
    i_RST_N = 1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic br, input bit abort);
    int c, n, base;
    c = cls_of(ins);
    n = 0;
    for (int k = 0; k <= wf; k++) begin
      i_INSTR = (k == wf) ? ins : $urandom;
      i_MEM_READY = (k == wf);
      i_BR_TAKEN = 1'($urandom);
      look(S_F);
      n++;
    end
    i_INSTR = ins;
    i_MEM_READY = 1'($urandom);
    look(S_D);
    n++;
    if (c < 0) begin
      exp_ill = 1;
      repeat (12) begin
        i_MEM_READY = 1'($urandom);
        i_BR_TAKEN = 1'($urandom);
        look(S_H);
      end
      #2 i_RST_N = 0;
      #1;
      chk("halt_rst_state", {29'd0, o_STATE}, 32'd0);
      chk("halt_rst_ill", {31'd0, o_ILLEGAL}, 32'd0);
      chk("halt_rst_req", {31'd0, o_MEM_REQ}, 32'd1);
      do_reset();
      return;
    end
    i_BR_TAKEN = br;
    i_MEM_READY = 1'($urandom);
    look(S_E);
    n++;
    if (c == C_LD || c == C_ST) begin
      for (int k = 0; k <= wm; k++) begin
        i_MEM_READY = (k == wm);
        i_BR_TAKEN = 1'($urandom);
        if (abort && k == 0) begin
          @(negedge i_CLK);
          now(S_M);
          #1 i_RST_N = 0;
          #1;
          chk("abort_we", {31'd0, o_MEM_WE}, 32'd0);
          chk("abort_state", {29'd0, o_STATE}, 32'd0);
          @(posedge i_CLK);
          #1;
          do_reset();
          return;
        end
        look(S_M);
        n++;
      end
    end
    if (c inside {C_R, C_OPI, C_LD, C_LUI, C_AUIPC}) begin
      i_MEM_READY = 1'($urandom);
      look(S_W);
      n++;
    end
    base = (c inside {C_BR, C_JAL, C_JALR}) ? 3 : (c == C_LD) ? 5 : 4;
    chk("cycles", n, base + wf + ((c == C_LD || c == C_ST) ? wm : 0));
  endtask

  initial begin
    logic [31:0] r, ins;
    int c;
    do_reset();
    run_instr(32'h002081B3, 0, 0, 0, 0);
    run_instr(32'h402081B3, 0, 0, 0, 0);
    run_instr(32'h0080A283, 0, 2, 0, 0);
    run_instr(32'h00208463, 0, 0, 1, 0);
    run_instr(32'h00208463, 0, 0, 0, 0);
    run_instr(32'h000100E7, 0, 0, 0, 0);
    run_instr(32'h008000EF, 1, 0, 0, 0);
    run_instr(32'h4030D093, 0, 0, 0, 0);
    run_instr(32'h40008093, 0, 0, 0, 0);
    run_instr(32'h123452B7, 0, 0, 0, 0);
    run_instr(32'h00001297, 2, 0, 0, 0);
    run_instr(32'h0020A423, 1, 1, 0, 0);
    run_instr(32'h0020A423, 1, 3, 0, 1);
    run_instr(32'h00000000, 0, 0, 0, 0);
    run_instr(32'h00000032, 0, 0, 0, 0);
    for (int i = 0; i < 250; i++) begin
      c = $urandom_range(0, 11);
      r = $urandom;
      if (c > 8) begin
        ins = r;
        while (cls_of(ins) >= 0) ins = $urandom;
      end else ins = {r[31:7], opc_of(c)};
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multi-cycle control unit for the RV32I core. It sequences instruction fetch, decode, execute, memory access and register write-back over the shared single-port memory, register file, ALU and PC/IR registers. It drives all datapath enables and muxes and handshakes with memory through a request/ready pair. It has no datapath storage of its own beyond its state and a sticky illegal-instruction flag.

## Interface
- BUS_WIDTH, 32, width of the instruction word input.
- i_CLK  in  1  rising-edge clock.
- i_RST_N  in  1  asynchronous active-low reset.
- i_INSTR  in  BUS_WIDTH  instruction register output. Valid from DECODE onward.
- i_MEM_READY  in  1  memory completion. Sampled only in FETCH and MEM.
- i_BR_TAKEN  in  1  branch comparator result for the funct3 of i_INSTR.
- o_MEM_REQ  out  1  memory request.
- o_MEM_WE  out  1  memory write (store).
- o_ADDR_SRC  out  1  memory address source: 0 = PC, 1 = ALU result.
- o_IR_WE  out  1  latch instruction register and OLD_PC (= PC).
- o_PC_WE  out  1  PC load.
- o_PC_SRC  out  2  next-PC source: 0 = PC+4, 1 = OLD_PC+imm, 2 = (rs1+imm) & ~1.
- o_ALU_SRCA  out  1  ALU operand A: 0 = rs1, 1 = OLD_PC.
- o_ALU_SRCB  out  1  ALU operand B: 0 = rs2, 1 = imm.
- o_ALU_OP  out  4  ALU operation as {alt, funct3}. 0000 = ADD, 1000 = SUB.
- o_REG_WE  out  1  register-file write.
- o_WB_SRC  out  2  write-back source: 0 = ALU, 1 = memory data, 2 = PC, 3 = imm.
- o_STATE  out  3  current state, for debug.
- o_ILLEGAL  out  1  sticky illegal-instruction flag.

## Operation
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5.
- Opcode classes (i_INSTR[6:0]): R = 0110011, OPI = 0010011, LOAD = 0000011, STORE = 0100011, BRANCH = 1100011, JAL = 1101111, JALR = 1100111, LUI = 0110111, AUIPC = 0010111.
- **FETCH**
  - o_MEM_REQ = 1, o_ADDR_SRC = 0.
  - On a rising edge with i_MEM_READY = 1: o_IR_WE = 1, o_PC_WE = 1 with o_PC_SRC = 0, next state DECODE.
  - Otherwise remain in FETCH.
- **DECODE**
  - Takes one cycle; all enables are 0.
  - Any opcode outside the list above, or i_INSTR[1:0] ≠ 11: next state HALT and o_ILLEGAL is set.
  - Any legal opcode: next state EXEC.
- **EXEC**
  - R: ALU_OP = {i_INSTR[30], funct3}, SRCB = 0. Next state WB.
  - OPI: SRCB = 1. ALU_OP = {i_INSTR[30], funct3} when funct3 = 101, else {0, funct3}. Next state WB.
  - LOAD, STORE: ALU_OP = 0000, SRCB = 1. Next state MEM.
  - AUIPC: SRCA = 1, SRCB = 1, ALU_OP = 0000. Next state WB.
  - LUI: no ALU use. Next state WB.
  - BRANCH: ALU_OP = 1000. When i_BR_TAKEN = 1, assert o_PC_WE with PC_SRC = 1. Next state FETCH.
  - JAL: o_PC_WE with PC_SRC = 1; o_REG_WE with WB_SRC = 2. PC already holds OLD_PC+4 and is read before the edge. Next state FETCH.
  - JALR: o_PC_WE with PC_SRC = 2, SRCB = 1; o_REG_WE with WB_SRC = 2. Next state FETCH.
- **MEM**
  - o_MEM_REQ = 1, o_ADDR_SRC = 1, o_MEM_WE = 1 for STORE. ALU_OP and SRCB are held at their EXEC values.
  - On i_MEM_READY = 1: LOAD goes to WB, STORE goes to FETCH.
  - Otherwise remain in MEM.
- **WB**
  - o_REG_WE = 1 for one cycle.
  - WB_SRC: 0 for R, OPI and AUIPC; 1 for LOAD; 3 for LUI.
  - ALU controls are held at their EXEC values. Next state FETCH.
- **HALT**
  - All enables and o_MEM_REQ are 0. o_ILLEGAL = 1.
  - HALT is left only through reset.
- Control outputs are combinational from state, i_INSTR and, where listed above, i_MEM_READY / i_BR_TAKEN. The state and o_ILLEGAL are registers.
- Any mux or ALU_OP field not specified for a state is driven to 0.
- Writes with rd = x0 are issued normally; the register file discards them.

## Timing
- **Reset values** (asserted asynchronously): state = FETCH, o_ILLEGAL = 0, o_STATE = 0.
  - While in reset the only nonzero outputs are o_MEM_REQ = 1 and the combinational i_MEM_READY-dependent terms.
  - Reset in MEM aborts the access; the store enable comes from MEM state and so drops with it.
- **Cycle counts** (zero-wait memory, FETCH taking 1 cycle):
  - BRANCH, JAL, JALR: 3 cycles.
  - R, OPI, LUI, AUIPC, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- **Memory handshake**
  - o_MEM_REQ stays high and the address stays stable until READY is sampled high.
  - READY in any other state is ignored.
  - READY is allowed to be permanently high.
- **Simultaneous events**
  - i_BR_TAKEN is sampled only in EXEC of BRANCH.
  - i_INSTR changes are tolerated in FETCH; the only outputs that depend on i_INSTR in FETCH are none.

## Test plan
- Reset with i_MEM_READY = 0 for 3 cycles → o_STATE = 0, o_MEM_REQ = 1, o_ILLEGAL = 0, all write enables 0.
- ADD x3,x1,x2 (0x002081B3), READY always 1 → states 0,1,2,4,0; o_ALU_OP = 0000 in EXEC; o_REG_WE = 1 only in WB with WB_SRC = 0. Repeat with SUB (0x402081B3) → ALU_OP = 1000.
- LW x5,8(x1) (0x0080A283) with 2 READY-low cycles in MEM → MEM occupies 3 cycles with ADDR_SRC = 1 and MEM_WE = 0; WB asserts REG_WE with WB_SRC = 1; 7 cycles total.
- BEQ (0x00208463) with i_BR_TAKEN = 1 → PC_WE with PC_SRC = 1 in EXEC; with i_BR_TAKEN = 0 → no PC_WE in EXEC; both return to FETCH after 3 cycles.
- JALR x1,0(x2) (0x000100E7) → EXEC asserts PC_WE with PC_SRC = 2 and REG_WE with WB_SRC = 2 in the same cycle.
- Instruction 0x00000000 → DECODE then HALT; o_ILLEGAL = 1 and o_MEM_REQ = 0 for 10 or more cycles; async reset → FETCH and o_ILLEGAL = 0. SW (0x0020A423) stalled in MEM, then reset asserted → o_MEM_WE drops immediately.
